// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the parametrised counter family.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Number of bits needed to hold the values 0..value-1.
  function automatic int clog2(input longint unsigned value);
    longint unsigned reach;
    int bits;
    reach = 64'd1;
    bits  = 0;
    while (reach < value) begin
      reach = reach << 1;
      bits++;
    end
    return bits;
  endfunction

endpackage

// File: rtl/updown_next.sv
// Next-count and overflow/underflow event logic for the up/down counter.
module updown_next
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 1,
  parameter int              SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_down_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] next_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam logic [WIDTH-1:0] MaxW   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MaxExt = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   OneExt = (WIDTH+1)'(1);

  logic [WIDTH:0] sumUp;
  logic [WIDTH:0] diffDown;
  logic           hitMax;
  logic           hitMin;

  // One extra bit so a non-power-of-two bound is detected instead of relying on rollover.
  assign sumUp    = {1'b0, count_i} + OneExt;
  assign diffDown = {1'b0, count_i} - OneExt;
  assign hitMax   = (sumUp > MaxExt);
  assign hitMin   = diffDown[WIDTH];

  always_comb begin
    next_o = count_i;
    ovf_o  = 1'b0;
    udf_o  = 1'b0;
    if (en_i) begin
      if (up_down_i == DIR_UP) begin
        if (hitMax) begin
          ovf_o  = 1'b1;
          next_o = (SATURATE == CNT_SAT) ? MaxW : '0;
        end else begin
          next_o = sumUp[WIDTH-1:0];
        end
      end else begin
        if (hitMin) begin
          udf_o  = 1'b1;
          next_o = (SATURATE == CNT_SAT) ? '0 : MaxW;
        end else begin
          next_o = diffDown[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, enable, wrap/saturate and event pulses.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 1,
  parameter int              SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             udf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be within 1..32");
  end

  if (clog2(MAX_VAL + 64'd1) > WIDTH) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] MaxW = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] stepNext;
  logic             stepOvf;
  logic             stepUdf;

  updown_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .count_i   (counter_q),
    .up_down_i (up_down),
    .en_i      (en),
    .next_o    (stepNext),
    .ovf_o     (stepOvf),
    .udf_o     (stepUdf)
  );

  // Load wins over counting and clamps out-of-range values to the top of the range.
  always_comb begin
    counter_d = stepNext;
    ovf_d     = stepOvf;
    udf_d     = stepUdf;
    if (load) begin
      counter_d = (load_val > MaxW) ? MaxW : load_val;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign counter = counter_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign at_max  = (counter_q == MaxW);
  assign at_min  = (counter_q == '0);

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter, the next generation of the team's fixed 4-bit up/down counter. It adds the following over the fixed version:
- configurable width and modulus;
- wrap or saturate mode;
- synchronous load and count enable;
- registered overflow/underflow event pulses.

It serves as the general-purpose counting primitive for timers, address sequencers and the future mini-projects that need bounded counts.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits; legal range 1..32.
- `MAX_VAL`, default 2**WIDTH-1: largest count value; must be ≤ 2**WIDTH-1; count range is 0..MAX_VAL.
- `SATURATE`, default 0: 0 selects wrap at the bounds; 1 selects hold at the bounds.

Ports (one clock; reset is synchronous and active-low):
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `en`  input  1  count enable.
- `up_down`  input  1  direction: 0 counts up, 1 counts down.
- `load`  input  1  synchronous load strobe.
- `load_val`  input  WIDTH  value to load.
- `counter`  output  WIDTH  current count, registered.
- `at_max`  output  1  high when `counter == MAX_VAL`; combinational decode of the register.
- `at_min`  output  1  high when `counter == 0`; combinational decode of the register.
- `ovf`  output  1  one-cycle pulse: an up-count was attempted at `MAX_VAL`; registered.
- `udf`  output  1  one-cycle pulse: a down-count was attempted at 0; registered.

## Operation
Each rising edge evaluates in priority order: reset, then load, then count, then hold.
- **Reset** (`reset==0`): `counter`=0, `ovf`=0, `udf`=0. Consequently `at_min`=1 and `at_max`=0, unless `MAX_VAL`=0, in which case both are 1.
- **Load** (`load==1`): `counter` = min(`load_val`, `MAX_VAL`). Out-of-range values are clamped, never wrapped. `en` and `up_down` are ignored. `ovf`/`udf` = 0.
- **Count up** (`en==1`, `up_down==0`):
  - below `MAX_VAL`: `counter`+1.
  - at `MAX_VAL`: goes to 0 when `SATURATE`=0, holds when `SATURATE`=1. `ovf`=1 for the next cycle in both modes.
- **Count down** (`en==1`, `up_down==1`):
  - above 0: `counter`-1.
  - at 0: goes to `MAX_VAL` when `SATURATE`=0, holds when `SATURATE`=1. `udf`=1 for the next cycle in both modes.
- **Hold** (`en==0`, no load): `counter` holds; `ovf`/`udf` = 0.
- **Arithmetic**: done in WIDTH+1 bits, with no reliance on natural 2**WIDTH rollover, so a non-power-of-two `MAX_VAL` wraps correctly.
- **Exclusivity**: `ovf` and `udf` are never high in the same cycle.
- **Direction change**: takes effect on the very next enabled edge. No pipeline or dead cycle.
- **Reset mid-count**: overrides everything on that edge, including a pending load. A pulse in flight is cleared.

## Timing
- **Latency**: `counter` updates one edge after the inputs are sampled, i.e. 1-cycle latency.
- **Flags**: `at_max`/`at_min` follow `counter` in the same cycle. `ovf`/`udf` assert in the same cycle as the wrapped/held `counter` value and last exactly one cycle per event.
- **Continuous events**: `en` held high at a bound in `SATURATE`=1 produces `ovf` (or `udf`) high on every cycle while the count is attempted.
- **Input timing**: all inputs are synchronous to `clk`. There are no asynchronous paths and no combinational path from any input to any output.

## Structure
- **Shared package `counter_pkg`**:
  - mode constants `CNT_WRAP`=0 and `CNT_SAT`=1;
  - direction constants `DIR_UP`=0 and `DIR_DOWN`=1, matching the existing counter's convention;
  - a width-checking helper, clog2.
- **Sub-module `updown_next`**: one natural combinational sub-module that computes the next count and the ovf/udf event bits from `counter`, `up_down`, `en` and the parameters. The top level holds the registers, the load/reset priority, and the flag decode.
- **Parameter checks**: illegal parameters (`MAX_VAL` > 2**WIDTH-1, `WIDTH`=0) raise an elaboration-time `$error`.

## Test plan
All scenarios except the last use `WIDTH`=4.
- **Reset/wrap up**: `MAX_VAL`=9, `SATURATE`=0. Hold `reset`=0 for 2 edges → `counter`=0, `at_min`=1. Release, `en`=1, `up_down`=0, 10 edges → 1..9, then 0, with `ovf` high only in the cycle `counter` returns to 0.
- **Wrap down**: `MAX_VAL`=9, `SATURATE`=0. Reset, then `up_down`=1, `en`=1 → the first edge gives 9 with `udf`=1, then 8..0.
- **Saturate**: `MAX_VAL`=15, `SATURATE`=1. Load 14, count up 3 edges → 15, 15, 15, with `ovf`=1 on the 2nd and 3rd edges. Count down from 1 for 2 edges → 0, 0, with `udf`=1 on the 2nd.
- **Load priority/clamp**: `MAX_VAL`=9. Load 13 with `en`=1 → `counter`=9, `ovf`=0. Assert `reset`=0 and `load`=1 on the same edge → `counter`=0.
- **Enable/direction**: toggle `en` low mid-count at 5 → holds 5 with no pulses. Flip `up_down` every edge with `en`=1 from 5 → 6, 5, 6, 5.
- **Full width**: `WIDTH`=8, `MAX_VAL`=255. 256 up-edges from 0 → returns to 0 with exactly one `ovf` pulse.
